io_bus_ctrl: RTL and testbench

Memory-mapped bus fabric directly downstream of the processor. It consumes the processor's ADDR, DOUT and W outputs, decodes the address, and gates writes into the synchronous program memory. It also owns the LED, HEX, switch and countdown-timer peripherals, and returns read data on the processor's DIN port with the same one-cycle latency as the memory.

---
 rtl/io_map_pkg.sv | 27 ++
 rtl/hex7seg.sv | 31 +++
 rtl/io_timer.sv | 86 ++++++++
 rtl/io_bus_ctrl.sv | 169 ++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: shared address map and types for the io_bus_ctrl fabric.
// Holds the region codes from ADDR[15:12] and the timer register offsets
// selected by ADDR[0]. It also holds the timer FSM state type, the blank
// seven-segment pattern and the number of HEX digits.
package io_map_pkg;

    // Region codes decoded from ADDR[15:12]
    localparam logic [3:0] IO_MEM = 4'h0;
    localparam logic [3:0] IO_LED = 4'h1;
    localparam logic [3:0] IO_HEX = 4'h2;
    localparam logic [3:0] IO_SW  = 4'h3;
    localparam logic [3:0] IO_TMR = 4'h4;

    // Timer register offsets, selected by ADDR[0]
    localparam logic TMR_COUNT  = 1'b0;
    localparam logic TMR_STATUS = 1'b1;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    // Active-low segments: all ones means every segment is dark
    localparam logic [6:0] HEX_BLANK = 7'h7F;
    localparam int         HEX_NUM   = 6;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational decoder from a hex nibble to active-low 7-segment
// bits. Bit 6 is segment g and bit 0 is segment a.
//   nib_i  in  4  hex digit
//   seg_o  out 7  active-low segment pattern
module hex7seg (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h7F;
        case (nib_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

// File: rtl/io_timer.sv
// io_timer: countdown timer with a prescaler and a two-state FSM (IDLE/RUN).
// It decrements the count once every PRESCALE cycles while in RUN. When the
// count goes from 1 to 0 it raises irq_o and returns to IDLE. A bus write
// on the same edge overrides the tick.
//   clk_i        in  1   clock
//   rst_ni       in  1   asynchronous active-low reset
//   wr_count_i   in  1   COUNT register write strobe
//   wr_status_i  in  1   STATUS register write strobe
//   wdata_i      in  16  write data
//   count_o      out 16  current count
//   run_o        out 1   FSM is in RUN
//   irq_o        out 1   expiry flag
module io_timer
    import io_map_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_count_i,
    input  logic        wr_status_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] count_o,
    output logic        run_o,
    output logic        irq_o
);
    localparam int          PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    tmr_state_e    state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          irq_q, irq_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TMR_IDLE;
            count_q <= '0;
            presc_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        irq_d   = irq_q;

        case (state_q)
            TMR_RUN: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        irq_d   = 1'b1;
                        state_d = TMR_IDLE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Bus writes come last so they win over a tick on the same edge
        if (wr_status_i && wdata_i[0]) begin
            irq_d = 1'b0;
        end
        if (wr_count_i) begin
            count_d = wdata_i;
            presc_d = '0;
            irq_d   = 1'b0;
            state_d = (wdata_i != 16'd0) ? TMR_RUN : TMR_IDLE;
        end
    end

    assign count_o = count_q;
    assign run_o   = (state_q == TMR_RUN);
    assign irq_o   = irq_q;
endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped bus fabric behind the processor. It decodes
// ADDR[15:12], gates memory writes and owns the LED, HEX, switch and timer
// peripherals. Read data comes back on DIN one cycle after the address,
// which matches the synchronous program memory.
// Optional build macro IO_HEX_DECODE_EN: HEX writes take a hex nibble and
// store the decoded segments (DOUT[7] blanks the digit). In that build HEX
// reads return the nibble.
//   Clock, Resetn       in   clock, asynchronous active-low reset
//   ADDR, DOUT, W       in   processor address, write data, write strobe
//   MEM_Q               in   synchronous memory read data
//   SW                  in   raw switches (asynchronous)
//   DIN                 out  read data to processor
//   MEM_WE              out  memory write enable
//   LEDR                out  LED register
//   HEX0..HEX5          out  active-low seven-segment patterns
//   TMR_IRQ             out  timer expired flag
module io_bus_ctrl
    import io_map_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int SW_W     = 10,
    parameter int LED_W    = 10
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [15:0]      ADDR,
    input  logic [15:0]      DOUT,
    input  logic             W,
    input  logic [15:0]      MEM_Q,
    input  logic [SW_W-1:0]  SW,
    output logic [15:0]      DIN,
    output logic             MEM_WE,
    output logic [LED_W-1:0] LEDR,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5,
    output logic             TMR_IRQ
);
    logic [3:0]         region;
    logic               wr_led, wr_hex, wr_count, wr_status;
    logic [HEX_NUM-1:0] hex_we;
    logic [6:0]         hex_wval;
    logic [6:0]         hex_q [HEX_NUM];
    logic [LED_W-1:0]   ledr_q;
    logic [SW_W-1:0]    sw_meta_q, sw_sync_q;
    logic [3:0]         sel_q;
    logic [15:0]        io_q, rd_val;
    logic [15:0]        tmr_count;
    logic               tmr_run, tmr_irq;
    logic               unused_addr;

    assign region      = ADDR[15:12];
    assign unused_addr = ^ADDR[11:3];

    assign MEM_WE    = W && (region == IO_MEM);
    assign wr_led    = W && (region == IO_LED);
    assign wr_hex    = W && (region == IO_HEX);
    assign wr_count  = W && (region == IO_TMR) && (ADDR[0] == TMR_COUNT);
    assign wr_status = W && (region == IO_TMR) && (ADDR[0] == TMR_STATUS);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ledr_q <= '0;
        end else if (wr_led) begin
            ledr_q <= DOUT[LED_W-1:0];
        end
    end

    // Two-flop synchronizer for the asynchronous switches
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

`ifdef IO_HEX_DECODE_EN
    logic [6:0] hex_seg;
    logic [3:0] hex_nib_q [HEX_NUM];

    hex7seg u_hex7seg (
        .nib_i (DOUT[3:0]),
        .seg_o (hex_seg)
    );
    assign hex_wval = DOUT[7] ? HEX_BLANK : hex_seg;
`else
    assign hex_wval = DOUT[6:0];
`endif

    for (genvar gi = 0; gi < HEX_NUM; gi++) begin : g_hex
        assign hex_we[gi] = wr_hex && (ADDR[2:0] == 3'(gi));

        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                hex_q[gi] <= HEX_BLANK;
            end else if (hex_we[gi]) begin
                hex_q[gi] <= hex_wval;
            end
        end
`ifdef IO_HEX_DECODE_EN
        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                hex_nib_q[gi] <= '0;
            end else if (hex_we[gi]) begin
                hex_nib_q[gi] <= DOUT[3:0];
            end
        end
`endif
    end

    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i       (Clock),
        .rst_ni      (Resetn),
        .wr_count_i  (wr_count),
        .wr_status_i (wr_status),
        .wdata_i     (DOUT),
        .count_o     (tmr_count),
        .run_o       (tmr_run),
        .irq_o       (tmr_irq)
    );

    // Peripheral read value before the edge; it is registered into io_q
    always_comb begin
        rd_val = '0;
        case (region)
            IO_LED: rd_val = 16'(ledr_q);
            IO_HEX: begin
                if (ADDR[2:0] < 3'(HEX_NUM)) begin
`ifdef IO_HEX_DECODE_EN
                    rd_val = 16'(hex_nib_q[ADDR[2:0]]);
`else
                    rd_val = 16'(hex_q[ADDR[2:0]]);
`endif
                end
            end
            IO_SW:  rd_val = 16'(sw_sync_q);
            IO_TMR: rd_val = (ADDR[0] == TMR_STATUS) ? {14'b0, tmr_run, tmr_irq} : tmr_count;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sel_q <= IO_MEM;
            io_q  <= '0;
        end else begin
            sel_q <= region;
            io_q  <= rd_val;
        end
    end

    assign DIN     = (sel_q == IO_MEM) ? MEM_Q : io_q;
    assign LEDR    = ledr_q;
    assign HEX0    = hex_q[0];
    assign HEX1    = hex_q[1];
    assign HEX2    = hex_q[2];
    assign HEX3    = hex_q[3];
    assign HEX4    = hex_q[4];
    assign HEX5    = hex_q[5];
    assign TMR_IRQ = tmr_irq;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed plus randomized bench for io_bus_ctrl (PRESCALE=4).
// The reference model keeps the timer as "cycles remaining until expiry".
// The visible count is that value divided by PRESCALE, rounded up.
module tb_io_bus_ctrl;
    localparam int P = 4;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] ADDR, DOUT, MEM_Q;
    logic        W;
    logic [9:0]  SW;
    logic [15:0] DIN;
    logic        MEM_WE;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        TMR_IRQ;

    io_bus_ctrl #(.PRESCALE(P), .SW_W(10), .LED_W(10)) dut (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .MEM_Q(MEM_Q), .SW(SW), .DIN(DIN), .MEM_WE(MEM_WE), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4),
        .HEX5(HEX5), .TMR_IRQ(TMR_IRQ)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0]  m_led;
    logic [6:0]  m_hex [6];
    int          m_r;       // cycles left until expiry; 0 means idle
    bit          m_irq;
    logic [3:0]  m_sel;
    logic [15:0] m_io;
    logic [9:0]  m_sw1, m_sw2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led = '0;
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
        m_r = 0; m_irq = 0; m_sel = 4'h0; m_io = '0;
        m_sw1 = '0; m_sw2 = '0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int idx;
        idx = int'(a[2:0]);
        case (a[15:12])
            4'h1: return 16'(m_led);
            4'h2: return (idx < 6) ? 16'(m_hex[idx]) : 16'h0;
            4'h3: return 16'(m_sw2);
            4'h4: return a[0] ? {14'b0, (m_r > 0), m_irq} : 16'((m_r + P - 1) / P);
            default: return 16'h0;
        endcase
    endfunction

    task automatic model_edge(input logic [15:0] a, input logic [15:0] d, input logic w,
                              input logic [9:0] sw);
        int idx;
        idx = int'(a[2:0]);
        m_io  = model_read(a);
        m_sel = a[15:12];
        m_sw2 = m_sw1;
        m_sw1 = sw;
        if (m_r > 0) begin
            m_r--;
            if (m_r == 0) m_irq = 1;
        end
        if (w) begin
            case (a[15:12])
                4'h1: m_led = d[9:0];
                4'h2: if (idx < 6) m_hex[idx] = d[6:0];
                4'h4: begin
                    if (!a[0]) begin
                        m_r = int'(d) * P;
                        m_irq = 0;
                    end else if (d[0]) begin
                        m_irq = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".DIN"}, 32'(DIN), 32'((m_sel == 4'h0) ? MEM_Q : m_io));
        chk({tag, ".LEDR"}, 32'(LEDR), 32'(m_led));
        chk({tag, ".HEX0"}, 32'(HEX0), 32'(m_hex[0]));
        chk({tag, ".HEX1"}, 32'(HEX1), 32'(m_hex[1]));
        chk({tag, ".HEX2"}, 32'(HEX2), 32'(m_hex[2]));
        chk({tag, ".HEX3"}, 32'(HEX3), 32'(m_hex[3]));
        chk({tag, ".HEX4"}, 32'(HEX4), 32'(m_hex[4]));
        chk({tag, ".HEX5"}, 32'(HEX5), 32'(m_hex[5]));
        chk({tag, ".IRQ"}, 32'(TMR_IRQ), 32'(m_irq));
    endtask

    // One bus cycle: drive inputs, check MEM_WE, clock, then check everything
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic w);
        ADDR = a; DOUT = d; W = w;
        #1;
        chk({tag, ".MEM_WE"}, 32'(MEM_WE), 32'(w && (a[15:12] == 4'h0)));
        @(posedge Clock);
        model_edge(a, d, w, SW);
        #1;
        compare_all(tag);
    endtask

    initial begin
        Resetn = 1'b1; ADDR = '0; DOUT = '0; W = 1'b0; SW = '0; MEM_Q = 16'hA5A5;
        model_reset();
        #2 Resetn = 1'b0;
        #1;
        chk("rst.LEDR", 32'(LEDR), 32'h0);
        chk("rst.HEX0", 32'(HEX0), 32'h7F);
        chk("rst.HEX5", 32'(HEX5), 32'h7F);
        chk("rst.IRQ", 32'(TMR_IRQ), 32'h0);
        chk("rst.DIN", 32'(DIN), 32'hA5A5);
        @(negedge Clock) Resetn = 1'b1;
        step("idle", 16'h0000, 16'h0, 1'b0);

        // Memory write enable is purely combinational
        ADDR = 16'h0005; W = 1'b1; #1;
        chk("memwe.mem", 32'(MEM_WE), 32'h1);
        ADDR = 16'h1000; #1;
        chk("memwe.led", 32'(MEM_WE), 32'h0);
        MEM_Q = 16'h1234;
        step("memrd", 16'h0005, 16'h0, 1'b0);
        chk("memrd.lit", 32'(DIN), 32'h1234);

        step("ledwr", 16'h1000, 16'h03FF, 1'b1);
        chk("ledwr.lit", 32'(LEDR), 32'h3FF);
        step("hexwr", 16'h2003, 16'h0024, 1'b1);
        chk("hexwr.lit", 32'(HEX3), 32'h24);
        step("ledrd", 16'h1000, 16'h0, 1'b0);
        chk("ledrd.lit", 32'(DIN), 32'h03FF);
        step("hex6wr", 16'h2006, 16'hFFFF, 1'b1);
        chk("hex6wr.lit", 32'(HEX3), 32'h24);

        SW = 10'h155;
        for (int i = 0; i < 3; i++) step("swrd", 16'h3000, 16'h0, 1'b0);
        chk("swrd.lit", 32'(DIN), 32'h0155);
        step("unmap", 16'h5000, 16'h0, 1'b0);
        chk("unmap.lit", 32'(DIN), 32'h0);

        // Countdown of 3 ticks at PRESCALE=4: expiry 12 edges after the write
        step("tmrwr", 16'h4000, 16'd3, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step("tmrrun", 16'h0000, 16'h0, 1'b0);
            chk("tmr12.lit", 32'(TMR_IRQ), (i == 12) ? 32'h1 : 32'h0);
        end
        step("tmrst", 16'h4001, 16'h0, 1'b0);
        chk("tmrst.lit", 32'(DIN), 32'h0001);
        step("tmrclr", 16'h4001, 16'h1, 1'b1);
        chk("tmrclr.lit", 32'(TMR_IRQ), 32'h0);

        // COUNT write on the edge where count would go 1 -> 0
        step("colw1", 16'h4000, 16'd1, 1'b1);
        for (int i = 0; i < 3; i++) step("colrun", 16'h0000, 16'h0, 1'b0);
        step("colw5", 16'h4000, 16'd5, 1'b1);
        chk("col.irq", 32'(TMR_IRQ), 32'h0);
        step("colcnt", 16'h4000, 16'h0, 1'b0);
        chk("col.cnt", 32'(DIN), 32'h5);
        step("colst", 16'h4001, 16'h0, 1'b0);
        chk("col.st", 32'(DIN), 32'h2);

        // Asynchronous reset between edges while the timer runs
        #2 Resetn = 1'b0;
        #1;
        model_reset();
        chk("arst.IRQ", 32'(TMR_IRQ), 32'h0);
        chk("arst.LEDR", 32'(LEDR), 32'h0);
        chk("arst.HEX3", 32'(HEX3), 32'h7F);
        chk("arst.DIN", 32'(DIN), 32'(MEM_Q));
        @(negedge Clock) Resetn = 1'b1;
        step("arst.st", 16'h4001, 16'h0, 1'b0);
        chk("arst.st.lit", 32'(DIN), 32'h0);
        step("arst.cnt", 16'h4000, 16'h0, 1'b0);
        chk("arst.cnt.lit", 32'(DIN), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  reg_sel;
            logic [15:0] a, d;
            logic        w;
            reg_sel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                                   : 4'($urandom_range(0, 4));
            a = {reg_sel, 12'($urandom)};
            d = 16'($urandom);
            if (reg_sel == 4'h4 && !a[0]) d = 16'($urandom_range(0, 5));
            w = ($urandom_range(0, 1) == 1);
            MEM_Q = 16'($urandom);
            if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
            step("rand", a, d, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
